// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and state encoding for the instruction fetch unit
package ifetch_pkg;

  // Next-PC select codes; the decode stage drives these same values.
  localparam logic [1:0] PC_NEXT_SEL_STALL  = 2'd0;
  localparam logic [1:0] PC_NEXT_SEL_PC_IMM = 2'd1;
  localparam logic [1:0] PC_NEXT_SEL_ABS    = 2'd2;
  localparam logic [1:0] PC_NEXT_SEL_RSVD   = 2'd3;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_npc.sv
// rtl/ifetch_npc.sv - combinational next-PC adder/mux with misalignment detect
module ifetch_npc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  sel,
  input  logic [31:0] off,
  input  logic [31:0] abs_target,
  output logic [31:0] npc,
  output logic        stall,
  output logic        misalign
);

  always_comb begin
    npc   = pc;
    stall = 1'b0;
    case (sel)
      PC_NEXT_SEL_STALL:  stall = 1'b1;
      PC_NEXT_SEL_PC_IMM: npc = pc + off;
      PC_NEXT_SEL_ABS:    npc = abs_target & ~32'h1;
      // The reserved code behaves as a plain sequential step.
      default:            npc = pc + 32'd4;
    endcase
    misalign = |npc[1:0];
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: owns the PC, fetches one word at a time, holds it for decode
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_req_addr_o,
  input  logic             mem_rsp_valid_i,
  input  logic [31:0]      mem_rsp_data_i,
  output logic             insn_valid_o,
  output logic [31:0]      insn_data_o,
  output logic [31:0]      insn_pc_o,
  input  logic             insn_ready_i,
  input  logic [1:0]       pc_next_sel_i,
  input  logic [31:0]      pc_next_off_i,
  input  logic [31:0]      pc_next_abs_i,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  ifetch_state_e state;
  logic [31:0]   pc;
  logic [31:0]   npc;
  logic          npc_stall;
  logic          npc_misalign;

  ifetch_npc u_npc (
    .pc         (pc),
    .sel        (pc_next_sel_i),
    .off        (pc_next_off_i),
    .abs_target (pc_next_abs_i),
    .npc        (npc),
    .stall      (npc_stall),
    .misalign   (npc_misalign)
  );

  // Every output is a flop; the request is raised on the edge that enters REQ.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= RESET_PC;
      insn_valid_o    <= 1'b0;
      insn_data_o     <= 32'h0;
      insn_pc_o       <= RESET_PC;
      misalign_o      <= 1'b0;
      fetch_cnt_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state           <= REQ;
          mem_req_valid_o <= 1'b1;
          mem_req_addr_o  <= pc;
        end
        REQ: begin
          if (mem_req_ready_i) begin
            state           <= WAIT;
            mem_req_valid_o <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            state        <= HOLD;
            insn_data_o  <= mem_rsp_data_i;
            insn_pc_o    <= pc;
            insn_valid_o <= 1'b1;
          end
        end
        HOLD: begin
          if (insn_ready_i) begin
            fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
            // A stall acceptance re-presents the same instruction.
            if (!npc_stall) begin
              insn_valid_o <= 1'b0;
              if (npc_misalign) begin
                misalign_o <= 1'b1;
                state      <= HALT;
              end else begin
                pc              <= npc;
                state           <= REQ;
                mem_req_valid_o <= 1'b1;
                mem_req_addr_o  <= npc;
              end
            end
          end
        end
        HALT: begin
          mem_req_valid_o <= 1'b0;
          insn_valid_o    <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          mem_req_valid_o <= 1'b0;
          insn_valid_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for the instruction fetch unit
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        insn_valid;
  logic [31:0] insn_data;
  logic [31:0] insn_pc;
  logic        insn_ready = 1'b0;
  logic [1:0]  pc_next_sel = 2'd0;
  logic [31:0] pc_next_off = 32'h0;
  logic [31:0] pc_next_abs = 32'h0;
  logic        misalign;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data),
    .insn_valid_o    (insn_valid),
    .insn_data_o     (insn_data),
    .insn_pc_o       (insn_pc),
    .insn_ready_i    (insn_ready),
    .pc_next_sel_i   (pc_next_sel),
    .pc_next_off_i   (pc_next_off),
    .pc_next_abs_i   (pc_next_abs),
    .misalign_o      (misalign),
    .fetch_cnt_o     (fetch_cnt)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  int          req_cyc_q[$];
  int          cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = 32'h0;
  logic        mem_hold = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_cnt = 32'h0;
  logic        m_mis = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model and request monitor, sampled mid-low-phase.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      cyc           = 0;
      pend          = 1'b0;
      mem_rsp_valid = 1'b0;
    end else begin
      mem_rsp_valid = pend && !mem_hold;
      mem_rsp_data  = mem_rsp_valid ? pend_data : $urandom;
      if (mem_req_valid && mem_req_ready) begin
        check_eq("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("req_addr", mem_req_addr, exp_q.pop_front());
        req_cyc_q.push_back(cyc);
        pend      = 1'b1;
        pend_data = mem_req_addr + 32'h13;
      end else begin
        pend = 1'b0;
      end
      cyc++;
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_req_addr", mem_req_addr, RESET_PC);
    check_eq("rst_insn_valid", 32'(insn_valid), 32'd0);
    check_eq("rst_insn_data", insn_data, 32'h0);
    check_eq("rst_insn_pc", insn_pc, RESET_PC);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_fetch_cnt", fetch_cnt, 32'h0);
    @(negedge clk);
    mem_hold   = 1'b0;
    insn_ready = 1'b0;
    exp_q.delete();
    req_cyc_q.delete();
    m_pc  = RESET_PC;
    m_cnt = 32'h0;
    m_mis = 1'b0;
    exp_q.push_back(RESET_PC);
    rst = 1'b0;
  endtask

  task automatic wait_insn;
    int n;
    n = 0;
    while (!insn_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("insn_wait", 32'(insn_valid), 32'd1);
  endtask

  task automatic accept(input logic [1:0] sel, input logic [31:0] off, input logic [31:0] tgt);
    logic [31:0] npc;
    wait_insn();
    if (!insn_valid) return;
    check_eq("insn_pc", insn_pc, m_pc);
    check_eq("insn_data", insn_data, m_pc + 32'h13);
    pc_next_sel = sel;
    pc_next_off = off;
    pc_next_abs = tgt;
    insn_ready  = 1'b1;
    case (sel)
      PC_NEXT_SEL_STALL:  npc = m_pc;
      PC_NEXT_SEL_PC_IMM: npc = m_pc + off;
      PC_NEXT_SEL_ABS:    npc = {tgt[31:1], 1'b0};
      default:            npc = m_pc + 32'd4;
    endcase
    m_cnt = m_cnt + 32'd1;
    if (sel != PC_NEXT_SEL_STALL) begin
      if (npc[1:0] == 2'b00) begin
        m_pc = npc;
        exp_q.push_back(npc);
      end else begin
        m_mis = 1'b1;
      end
    end
    @(negedge clk);
    insn_ready  = 1'b0;
    pc_next_sel = 2'($urandom);
    pc_next_off = $urandom;
    pc_next_abs = $urandom;
    check_eq("fetch_cnt", fetch_cnt, m_cnt);
    check_eq("misalign", 32'(misalign), 32'(m_mis));
    check_eq("insn_valid_after", 32'(insn_valid), 32'(sel == PC_NEXT_SEL_STALL));
    if (sel != PC_NEXT_SEL_STALL && !m_mis) begin
      check_eq("next_req_valid", 32'(mem_req_valid), 32'd1);
      check_eq("next_req_addr", mem_req_addr, m_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Back-to-back sequential fetch and its cycle timing.
    do_reset();
    mem_req_ready = 1'b1;
    repeat (3) accept(PC_NEXT_SEL_PC_IMM, 32'd4, $urandom);
    check_eq("t1_req_cyc0", 32'(req_cyc_q[0]), 32'd1);
    check_eq("t1_req_cyc1", 32'(req_cyc_q[1]), 32'd4);
    check_eq("t1_req_cyc2", 32'(req_cyc_q[2]), 32'd7);

    // Request held off by memory backpressure.
    do_reset();
    accept(PC_NEXT_SEL_PC_IMM, 32'd4, $urandom);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_req_valid", 32'(mem_req_valid), 32'd1);
      check_eq("bp_req_addr", mem_req_addr, 32'h4);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;

    // Stalls re-present the instruction, then a backward branch.
    repeat (3) accept(PC_NEXT_SEL_PC_IMM, 32'd4, $urandom);
    repeat (3) accept(PC_NEXT_SEL_STALL, $urandom, $urandom);
    accept(PC_NEXT_SEL_PC_IMM, 32'hFFFF_FFF8, $urandom);
    accept(PC_NEXT_SEL_RSVD, $urandom, $urandom);

    // Wrap from the top of the address space.
    accept(PC_NEXT_SEL_ABS, $urandom, 32'hFFFF_FFFD);
    accept(PC_NEXT_SEL_PC_IMM, 32'd4, $urandom);
    accept(PC_NEXT_SEL_PC_IMM, 32'd8, $urandom);

    // Misaligned jump halts fetch until reset.
    accept(PC_NEXT_SEL_ABS, $urandom, 32'h0000_1003);
    repeat (10) @(negedge clk);
    check_eq("halt_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("halt_insn_valid", 32'(insn_valid), 32'd0);
    check_eq("halt_misalign", 32'(misalign), 32'd1);
    check_eq("halt_no_pending", 32'(exp_q.size()), 32'd0);
    do_reset();
    accept(PC_NEXT_SEL_PC_IMM, 32'd4, $urandom);

    // Asynchronous reset in WAIT and in HOLD.
    do_reset();
    mem_hold = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("wait_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("wait_insn_valid", 32'(insn_valid), 32'd0);
    do_reset();
    accept(PC_NEXT_SEL_PC_IMM, 32'd8, $urandom);
    wait_insn();
    do_reset();
    accept(PC_NEXT_SEL_PC_IMM, 32'd4, $urandom);
    repeat (6) @(negedge clk);
    check_eq("req_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
